// File: rtl/gear_shift_sequencer_if.sv
// Shift handshake between the gear sequencer (master) and the shift actuator (slave).
interface gear_shift_sequencer_if;
  logic       shift_req;
  logic [1:0] shift_tgt;
  logic       shift_ack;

  modport master (output shift_req, output shift_tgt, input shift_ack);
  modport slave  (input shift_req, input shift_tgt, output shift_ack);
endinterface

// File: rtl/gear_shift_sequencer.sv
// Steps the engaged drive mode one gear at a time toward the requested mode,
// with an actuator ack timeout, a post-shift dwell and a sticky fault.
module gear_shift_sequencer #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          A,
  input  logic [1:0]                    C,
  gear_shift_sequencer_if.master        act,
  output logic [1:0]                    M,
  output logic                          AC,
  output logic                          busy,
  output logic                          fault
);

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_FAULT
  } state_t;

  localparam logic [7:0] ACK_LOAD  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] m_n, tgt_n, t_eff;
  logic [7:0] ack_cnt, ack_cnt_n;
  logic [7:0] hold_cnt, hold_cnt_n;

  always_comb begin
    state_n    = state;
    m_n        = M;
    tgt_n      = act.shift_tgt;
    ack_cnt_n  = ack_cnt;
    hold_cnt_n = hold_cnt;
    t_eff      = A ? C : 2'b00;

    case (state)
      S_OFF: begin
        if (A) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (t_eff == M) begin
          if (!A && M == 2'b00) state_n = S_OFF;
        end else begin
          state_n   = S_REQ;
          tgt_n     = (t_eff > M) ? M + 2'd1 : M - 2'd1;
          ack_cnt_n = ACK_LOAD;
        end
      end
      S_REQ: begin
        // Ack wins over an expiring timeout on the same edge.
        if (act.shift_ack) begin
          m_n        = act.shift_tgt;
          state_n    = S_HOLD;
          hold_cnt_n = HOLD_LOAD;
        end else if (ack_cnt == '0) begin
          state_n = S_FAULT;
        end else begin
          ack_cnt_n = ack_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (hold_cnt == '0) state_n = S_IDLE;
        else                hold_cnt_n = hold_cnt - 8'd1;
      end
      S_FAULT: begin
        state_n = S_FAULT;
      end
      default: state_n = S_OFF;
    endcase
  end

  // Outputs are registered from the next-state decode so they track state with no input path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_OFF;
      M             <= '0;
      act.shift_tgt <= '0;
      act.shift_req <= 1'b0;
      AC            <= 1'b0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      ack_cnt       <= '0;
      hold_cnt      <= '0;
    end else begin
      state         <= state_n;
      M             <= m_n;
      act.shift_tgt <= tgt_n;
      act.shift_req <= (state_n == S_REQ);
      AC            <= (state_n != S_OFF);
      busy          <= (state_n == S_REQ) || (state_n == S_HOLD);
      fault         <= (state_n == S_FAULT);
      ack_cnt       <= ack_cnt_n;
      hold_cnt      <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_gear_shift_sequencer.sv
// Directed bench for gear_shift_sequencer with HOLD_CYCLES=4, ACK_TIMEOUT=6.
module tb_gear_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       A;
  logic [1:0] C;
  logic [1:0] M;
  logic       AC, busy, fault;

  gear_shift_sequencer_if act_if ();

  gear_shift_sequencer #(
    .HOLD_CYCLES(4),
    .ACK_TIMEOUT(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .C     (C),
    .act   (act_if.master),
    .M     (M),
    .AC    (AC),
    .busy  (busy),
    .fault (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic [1:0] c;
    logic       ack;
    logic       req;
    logic [1:0] tgt;
    logic [1:0] m;
    logic       ac;
    logic       busy;
    logic       fault;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input int a, input int c, input int ack, input int req,
                             input int tgt, input int m, input int ac, input int bsy,
                             input int f);
    vec_t r;
    r.a = 1'(a); r.c = 2'(c); r.ack = 1'(ack);
    r.req = 1'(req); r.tgt = 2'(tgt); r.m = 2'(m);
    r.ac = 1'(ac); r.busy = 1'(bsy); r.fault = 1'(f);
    return r;
  endfunction

  task automatic chk(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input int req, input int tgt, input int m,
                         input int ac, input int bsy, input int f);
    chk({tag, ".shift_req"}, int'(act_if.shift_req), req);
    chk({tag, ".shift_tgt"}, int'(act_if.shift_tgt), tgt);
    chk({tag, ".M"},         int'(M),                m);
    chk({tag, ".AC"},        int'(AC),               ac);
    chk({tag, ".busy"},      int'(busy),             bsy);
    chk({tag, ".fault"},     int'(fault),            f);
  endtask

  task automatic set_in(input int a, input int c, input int ack);
    A = 1'(a);
    C = 2'(c);
    act_if.shift_ack = 1'(ack);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge, released on a falling edge.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk_all(tag, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all({tag, "_rel"}, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // a, c, ack | req, tgt, M, AC, busy, fault  -- state after the edge
    vecs.push_back(v(1,0,0, 0,0,0,1,0,0)); // OFF -> IDLE
    vecs.push_back(v(1,3,0, 1,1,0,1,1,0)); // IDLE -> REQ 01
    vecs.push_back(v(1,3,1, 0,1,1,1,1,0)); // ack -> HOLD, M=01
    vecs.push_back(v(1,3,0, 0,1,1,1,1,0));
    vecs.push_back(v(1,3,1, 0,1,1,1,1,0)); // ack in HOLD ignored
    vecs.push_back(v(1,3,0, 0,1,1,1,1,0));
    vecs.push_back(v(1,3,0, 0,1,1,1,0,0)); // HOLD -> IDLE
    vecs.push_back(v(1,3,0, 1,2,1,1,1,0)); // REQ 10, 5 edges after ack
    vecs.push_back(v(1,3,1, 0,2,2,1,1,0));
    vecs.push_back(v(1,3,0, 0,2,2,1,1,0));
    vecs.push_back(v(1,3,0, 0,2,2,1,1,0));
    vecs.push_back(v(1,3,0, 0,2,2,1,1,0));
    vecs.push_back(v(1,3,0, 0,2,2,1,0,0));
    vecs.push_back(v(1,3,0, 1,3,2,1,1,0)); // REQ 11
    vecs.push_back(v(1,3,1, 0,3,3,1,1,0));
    vecs.push_back(v(1,3,0, 0,3,3,1,1,0));
    vecs.push_back(v(1,3,0, 0,3,3,1,1,0));
    vecs.push_back(v(1,3,0, 0,3,3,1,1,0));
    vecs.push_back(v(1,3,0, 0,3,3,1,0,0)); // IDLE, T==M
    vecs.push_back(v(1,3,1, 0,3,3,1,0,0)); // ack in IDLE ignored
    vecs.push_back(v(1,2,0, 1,2,3,1,1,0)); // downshift request 10
    vecs.push_back(v(1,2,1, 0,2,2,1,1,0)); // M=10, HOLD
    vecs.push_back(v(0,2,0, 0,2,2,1,1,0)); // engine off ignored during HOLD
    vecs.push_back(v(0,0,0, 0,2,2,1,1,0));
    vecs.push_back(v(0,0,0, 0,2,2,1,1,0));
    vecs.push_back(v(0,0,0, 0,2,2,1,0,0)); // IDLE
    vecs.push_back(v(0,0,0, 1,1,2,1,1,0)); // REQ 01
    vecs.push_back(v(0,0,1, 0,1,1,1,1,0));
    vecs.push_back(v(0,0,0, 0,1,1,1,1,0));
    vecs.push_back(v(0,0,0, 0,1,1,1,1,0));
    vecs.push_back(v(0,0,0, 0,1,1,1,1,0));
    vecs.push_back(v(0,0,0, 0,1,1,1,0,0));
    vecs.push_back(v(0,0,0, 1,0,1,1,1,0)); // REQ 00
    vecs.push_back(v(0,0,1, 0,0,0,1,1,0));
    vecs.push_back(v(0,0,0, 0,0,0,1,1,0));
    vecs.push_back(v(0,0,0, 0,0,0,1,1,0));
    vecs.push_back(v(0,0,0, 0,0,0,1,1,0));
    vecs.push_back(v(0,0,0, 0,0,0,1,0,0)); // IDLE at 00
    vecs.push_back(v(0,0,0, 0,0,0,0,0,0)); // -> OFF
    vecs.push_back(v(0,0,1, 0,0,0,0,0,0)); // ack in OFF ignored

    reset = 1'b1;
    set_in(0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("por", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      set_in(int'(vecs[i].a), int'(vecs[i].c), int'(vecs[i].ack));
      step();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].req), int'(vecs[i].tgt), int'(vecs[i].m),
              int'(vecs[i].ac), int'(vecs[i].busy), int'(vecs[i].fault));
    end

    // Timeout: request stays high exactly 6 cycles, C/A changes do not disturb it.
    set_in(1, 1, 0);
    step();
    chk_all("to_idle", 0, 0, 0, 1, 0, 0);
    step();
    chk_all("to_req1", 1, 1, 0, 1, 1, 0);
    for (int i = 2; i <= 6; i++) begin
      if (i == 3) set_in(1, 3, 0);
      if (i == 4) set_in(0, 0, 0);
      step();
      chk_all($sformatf("to_req%0d", i), 1, 1, 0, 1, 1, 0);
    end
    step();
    chk_all("to_fault", 0, 1, 0, 1, 0, 1);
    set_in(1, 1, 1);
    step();
    chk_all("fault_ack", 0, 1, 0, 1, 0, 1);
    set_in(0, 0, 0);
    step();
    chk_all("fault_sticky", 0, 1, 0, 1, 0, 1);
    pulse_reset("rst_fault");

    // Ack arriving on the timeout edge completes the shift.
    set_in(1, 1, 0);
    step();
    step();
    chk_all("sim_req", 1, 1, 0, 1, 1, 0);
    repeat (5) step();
    chk_all("sim_last", 1, 1, 0, 1, 1, 0);
    set_in(1, 1, 1);
    step();
    chk_all("sim_ack", 0, 1, 1, 1, 1, 0);
    set_in(1, 2, 0);
    repeat (3) step();
    chk_all("sim_hold", 0, 1, 1, 1, 1, 0);
    step();
    chk_all("sim_idle", 0, 1, 1, 1, 0, 0);
    step();
    chk_all("up2_req", 1, 2, 1, 1, 1, 0);
    set_in(1, 2, 1);
    step();
    chk_all("up2_ack", 0, 2, 2, 1, 1, 0);
    set_in(1, 2, 0);
    step();
    chk_all("mid_hold", 0, 2, 2, 1, 1, 0);
    pulse_reset("rst_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gear_shift_sequencer.md
GEAR_SHIFT_SEQUENCER -- requirements
Module: gear_shift_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 8, SHALL set the minimum dwell in cycles after each completed shift (legal range 1..255).
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum cycles shift_req waits for shift_ack before fault (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset (0 = reset asserted).
REQ-005 A  input  1  SHALL be engine on (1) / off (0).
REQ-006 C  input  2  SHALL be the requested mode from the revolution FSM: 00 neutral, 01 eco, 10 normal, 11 sport.
REQ-007 shift_ack  input  1  SHALL be the actuator acknowledge for the pending shift.
REQ-008 shift_req  output  1  SHALL request the actuator to engage shift_tgt.
REQ-009 shift_tgt  output  2  SHALL be the mode being requested.
REQ-010 M  output  2  SHALL be the currently engaged mode, same encoding as C.
REQ-011 AC  output  1  SHALL indicate car on (state not OFF).
REQ-012 busy  output  1  SHALL be high in states REQ and HOLD.
REQ-013 fault  output  1  SHALL be high in state FAULT.

Function
REQ-014 All outputs SHALL be registered, driven from state and M, with no combinational path from inputs to outputs.
REQ-015 State machine SHALL have states OFF, IDLE, REQ, HOLD, FAULT.
REQ-016 Effective target T SHALL be C when A=1 and 00 when A=0.
REQ-017 OFF: when A=1, the next state SHALL be IDLE; otherwise the state SHALL remain OFF.
REQ-018 IDLE: if T==M and A=0 and M==00, the next state SHALL be OFF; if T==M otherwise, the state SHALL remain IDLE.
REQ-019 IDLE: if T!=M, the next state SHALL be REQ with shift_tgt = M+1 when T>M, else M-1 (one step per shift, never skipping modes).
REQ-020 REQ: shift_req SHALL be 1 and shift_tgt SHALL be stable; C and A changes SHALL NOT alter or abort the pending request.
REQ-021 REQ: shift_ack=1 on an edge SHALL update M to shift_tgt on that edge, deassert shift_req, and enter HOLD.
REQ-022 REQ: if shift_req has been high ACK_TIMEOUT cycles without ack, the next edge SHALL enter FAULT; ack on that same edge SHALL win (normal completion).
REQ-023 HOLD: the state SHALL remain HOLD for exactly HOLD_CYCLES cycles, then enter IDLE; C and A SHALL be ignored during HOLD.
REQ-024 shift_ack while not in REQ SHALL be ignored.
REQ-025 FAULT: shift_req SHALL be 0, M SHALL hold its last value, AC SHALL be 1, fault SHALL be 1; FAULT SHALL be sticky until reset.
REQ-026 The ack-timeout and hold counters SHALL be 8 bits wide, reloaded on REQ and HOLD entry respectively, and SHALL NOT wrap.
REQ-027 Shift latency: T!=M sampled in IDLE on edge k SHALL give shift_req=1 after edge k; the earliest following request SHALL rise HOLD_CYCLES+1 cycles after the ack edge.

Reset
REQ-028 When reset=0, the block SHALL immediately enter OFF with M=00, shift_tgt=00, shift_req=0, AC=0, busy=0, fault=0, counters cleared, including mid-REQ or mid-HOLD.
REQ-029 Reset release SHALL take effect synchronously: the first state evaluation SHALL occur on the first rising edge with reset=1.

Verification (HOLD_CYCLES=4, ACK_TIMEOUT=6)
REQ-030 Power-up test: reset low, then A=1, C=00 -> AC=1 one edge later, M=00, shift_req never asserted.
REQ-031 Upshift test: A=1, C=11 from M=00, ack one cycle after each req -> shift_tgt 01, 10, 11 in order, M steps 00->01->10->11, requests 5 cycles after each ack.
REQ-032 Engine-off test: M=10, A falls -> stepwise downshift 10->01->00, then OFF, AC=0.
REQ-033 Timeout test: C=01 from M=00, shift_ack held 0 -> shift_req high exactly 6 cycles, then fault=1, shift_req=0, M=00; later ack ignored.
REQ-034 Simultaneous-events test: ack on the timeout edge -> M=01, HOLD, fault=0; separately, C changing mid-REQ -> shift_tgt unchanged.
REQ-035 Reset-mid-operation test: reset=0 during HOLD with M=10 -> all outputs return to their reset values immediately, without waiting for clk.
